// File: rtl/divsub_unit_if.sv
// Request/response bundle for divsub_unit: operands and start in, result and
// status out. master drives requests, slave is the arithmetic unit.
interface divsub_unit_if #(
    parameter int p_width = 4
);
    logic                   i_w_start;
    logic                   i_w_sel;
    logic [p_width-1:0]     i_w_a;
    logic [p_width-1:0]     i_w_b;
    logic [2*p_width-1:0]   o_w_out;
    logic                   o_w_busy;
    logic                   o_w_done;
    logic                   o_w_div0;

    modport master (
        output i_w_start,
        output i_w_sel,
        output i_w_a,
        output i_w_b,
        input  o_w_out,
        input  o_w_busy,
        input  o_w_done,
        input  o_w_div0
    );

    modport slave (
        input  i_w_start,
        input  i_w_sel,
        input  i_w_a,
        input  i_w_b,
        output o_w_out,
        output o_w_busy,
        output o_w_done,
        output o_w_div0
    );
endinterface

// File: rtl/divsub_unit.sv
// Subtract / restoring-divide unit with start-busy-done framing.
// Optional DIVSUB_EARLY_OUT_EN: divide with a < b finishes without DIV steps.
module divsub_unit #(
    parameter int p_width = 4
) (
    input  logic         i_w_clk,
    input  logic         i_w_reset,
    divsub_unit_if.slave bus
);
    localparam int CW = $clog2(p_width + 1);
    localparam int OW = 2 * p_width;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [p_width:0]   rem_q, rem_d;
    logic [p_width-1:0] quo_q, quo_d;
    logic [p_width-1:0] dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OW-1:0]      out_q, out_d;
    logic               div0_q, div0_d;

    logic [p_width:0]   sub_diff;
    logic [p_width+1:0] shl;
    logic [p_width+1:0] trial;
    logic               trial_ok;
    logic               is_sub;
    logic               is_div0;
    logic               is_early;
    logic               is_div;

    // Borrow lands in bit p_width of the widened difference.
    assign sub_diff = {1'b0, bus.i_w_a} - {1'b0, bus.i_w_b};

    assign shl      = {rem_q, quo_q[p_width-1]};
    assign trial    = shl - {2'b00, dvs_q};
    assign trial_ok = ~trial[p_width+1];

    assign is_sub  = ~bus.i_w_sel;
    assign is_div0 = bus.i_w_sel & (bus.i_w_b == '0);
`ifdef DIVSUB_EARLY_OUT_EN
    assign is_early = bus.i_w_sel & (bus.i_w_b != '0)
                    & (bus.i_w_a < bus.i_w_b);
`else
    assign is_early = 1'b0;
`endif
    assign is_div = bus.i_w_sel & (bus.i_w_b != '0) & ~is_early;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        div0_d  = div0_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_w_start) begin
                    dvs_d = bus.i_w_b;
                    unique case (1'b1)
                        is_sub: begin
                            state_d = ST_DONE;
                            out_d   = OW'(sub_diff);
                            div0_d  = 1'b0;
                        end
                        is_div0: begin
                            state_d = ST_DONE;
                            out_d   = {bus.i_w_a, {p_width{1'b1}}};
                            div0_d  = 1'b1;
                        end
                        is_early: begin
                            state_d = ST_DONE;
                            out_d   = {bus.i_w_a, {p_width{1'b0}}};
                            div0_d  = 1'b0;
                        end
                        is_div: begin
                            state_d = ST_DIV;
                            rem_d   = '0;
                            quo_d   = bus.i_w_a;
                            cnt_d   = CW'(p_width);
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV: begin
                rem_d = trial_ok ? trial[p_width:0] : shl[p_width:0];
                quo_d = {quo_q[p_width-2:0], trial_ok};
                cnt_d = cnt_q - CW'(1);
                // Final step publishes the freshly computed pair.
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    out_d   = {rem_d[p_width-1:0], quo_d};
                    div0_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            div0_q  <= div0_d;
        end
    end

    assign bus.o_w_out  = out_q;
    assign bus.o_w_div0 = div0_q;
    assign bus.o_w_busy = (state_q != ST_IDLE);
    assign bus.o_w_done = (state_q == ST_DONE);
endmodule

// File: tb/tb_divsub_unit.sv
// Scoreboard bench for divsub_unit: arithmetic reference model, latency and
// handshake checks, reset mid-divide, dropped starts and random operations.
module tb_divsub_unit;
    localparam int P  = 4;
    localparam int OW = 2 * P;
    localparam int M  = 1 << P;

    typedef struct {
        logic [OW-1:0] out;
        logic          div0;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divsub_unit_if #(.p_width(P)) bus();

    divsub_unit #(.p_width(P)) dut (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .bus       (bus)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Difference modulo 2^(P+1); quotient/remainder via plain / and %.
    function automatic exp_t model(bit sel, int a, int b, int acc);
        exp_t e;
        int   lat;
        lat = 1;
        if (!sel) begin
            e.out  = OW'((a - b + 2 * M) % (2 * M));
            e.div0 = 1'b0;
        end else if (b == 0) begin
            e.out  = OW'(a * M + (M - 1));
            e.div0 = 1'b1;
        end else begin
            e.out  = OW'((a % b) * M + a / b);
            e.div0 = 1'b0;
`ifdef DIVSUB_EARLY_OUT_EN
            lat = (a < b) ? 1 : P + 1;
`else
            lat = P + 1;
`endif
        end
        e.cyc = acc + lat - 1;
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.o_w_done === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done at cycle %0d, required none",
                         cyc);
            end else begin
                e = sbq.pop_front();
                chk("result", 32'(bus.o_w_out), 32'(e.out));
                chk("div0", 32'(bus.o_w_div0), 32'(e.div0));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge with the unit idle; returns just after accept.
    task automatic issue(bit sel, int a, int b);
        bus.i_w_start = 1'b1;
        bus.i_w_sel   = sel;
        bus.i_w_a     = P'(a);
        bus.i_w_b     = P'(b);
        @(posedge clk);
        #1;
        sbq.push_back(model(sel, a, b, cyc));
        bus.i_w_start = 1'b0;
        bus.i_w_sel   = 1'($urandom_range(0, 1));
        bus.i_w_a     = P'($urandom_range(0, M - 1));
        bus.i_w_b     = P'($urandom_range(0, M - 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.o_w_busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_w_start = 1'b0;
        bus.i_w_sel   = 1'b0;
        bus.i_w_a     = '0;
        bus.i_w_b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 32'(bus.o_w_out), 32'h0);
        chk("rst_busy", 32'(bus.o_w_busy), 32'h0);
        chk("rst_done", 32'(bus.o_w_done), 32'h0);
        chk("rst_div0", 32'(bus.o_w_div0), 32'h0);
        rst = 1'b0;

        issue(0, 9, 3);
        wait_idle();
        issue(0, 3, 9);
        wait_idle();
        repeat (3) begin
            chk("hold_idle", 32'(bus.o_w_out), 32'h1A);
            @(negedge clk);
        end

        issue(1, 13, 4);
        for (int i = 1; i <= P + 1; i++) begin
            @(negedge clk);
            chk("div_busy", 32'(bus.o_w_busy), 32'h1);
            chk("div_done", 32'(bus.o_w_done), 32'(i == P + 1));
            if (i < P + 1) chk("div_hold", 32'(bus.o_w_out), 32'h1A);
        end
        @(negedge clk);
        chk("div_idle", 32'(bus.o_w_busy), 32'h0);
        issue(1, 15, 1);
        wait_idle();
        issue(1, 15, 15);
        wait_idle();

        issue(1, 7, 0);
        wait_idle();
        issue(0, 5, 5);
        wait_idle();

        issue(1, 13, 4);
        @(negedge clk);
        @(negedge clk);
        bus.i_w_start = 1'b1;
        bus.i_w_sel   = 1'b0;
        bus.i_w_a     = 4'd5;
        bus.i_w_b     = 4'd1;
        @(negedge clk);
        bus.i_w_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.i_w_start = 1'b1;
        @(negedge clk);
        bus.i_w_start = 1'b0;
        repeat (3) begin
            chk("drop_hold", 32'(bus.o_w_out), 32'h13);
            @(negedge clk);
        end

        issue(1, 13, 4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.o_w_busy), 32'h0);
        chk("mid_rst_out", 32'(bus.o_w_out), 32'h0);
        chk("mid_rst_done", 32'(bus.o_w_done), 32'h0);
        chk("mid_rst_div0", 32'(bus.o_w_div0), 32'h0);
        rst = 1'b0;
        issue(0, 9, 3);
        wait_idle();

        issue(1, 2, 9);
        wait_idle();

        repeat (60) begin
            int s, a, b;
            s = $urandom_range(0, 1);
            a = $urandom_range(0, M - 1);
            b = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, M - 1);
            issue(s[0], a, b);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/divsub_unit.md
# divsub_unit

Sequential inverse-arithmetic unit that pairs with the add/multiply ALU: it computes the difference or the unsigned quotient and remainder of two `p_width`-bit operands. Subtraction completes in one cycle. Division is a restoring divider that retires one quotient bit per cycle. A start/busy/done handshake frames each operation. Result packing matches the ALU's `2*p_width`-bit output bus, so both units can share a result path.

## Interface
- `p_width`, default 4: operand width in bits; legal range ≥ 2.
- `i_w_clk`, input, 1: clock. All state changes on its rising edge.
- `i_w_reset`, input, 1: **synchronous, active-high** reset.
- `i_w_start`, input, 1: request. Accepted only in IDLE.
- `i_w_sel`, input, 1: operation select. 0 = subtract, 1 = divide.
- `i_w_a`, input, `p_width`: minuend or dividend, unsigned.
- `i_w_b`, input, `p_width`: subtrahend or divisor, unsigned.
- `o_w_out`, output, `2*p_width`: registered result (packing under Operation).
- `o_w_busy`, output, 1: high in every state except IDLE.
- `o_w_done`, output, 1: one-cycle pulse; result is valid in that cycle.
- `o_w_div0`, output, 1: divide-by-zero flag. Updated together with `o_w_out`.

## Operation
- **Operand capture:** on the accepting edge (IDLE and `i_w_start`=1), `i_w_a`, `i_w_b` and `i_w_sel` are latched. Later changes to the inputs are ignored until the next accept.
- **States:** IDLE, DIV, DONE.
- **IDLE transitions:**
  - Subtract: go to DONE. On the same edge, `o_w_out` is loaded with the `p_width+1`-bit two's-complement `a-b`, zero-extended. Bit `p_width` is the borrow. `o_w_div0` is cleared.
  - Divide with `b`==0: go to DONE. `o_w_out` = {`a`, all-ones}, i.e. remainder = `a`, quotient = 2^`p_width`-1. `o_w_div0` is set.
  - Divide with `b`≠0: go to DIV. Remainder register (`p_width+1` bits) is cleared, quotient register is loaded with `a`, step counter is loaded with `p_width`.
- **DIV, each cycle:**
  - Shift {remainder, quotient} left by 1.
  - Trial = remainder − `b`. If trial ≥ 0, remainder = trial and quotient LSB = 1. Otherwise restore and set quotient LSB = 0.
  - Decrement the counter.
  - On the step where the counter reaches 0, go to DONE. On that same edge, load `o_w_out` = {remainder[`p_width`-1:0], quotient} and clear `o_w_div0`.
- **DONE:** `o_w_done`=1 for exactly this cycle, then IDLE unconditionally. `i_w_start` is ignored in this cycle.
- **Result hold:** `o_w_out` and `o_w_div0` hold until the next operation completes. They never change in IDLE or DIV.
- **Busy:** `i_w_start` while `o_w_busy`=1 is dropped. It is not queued.
- **Reset:** may be asserted at any point, including mid-DIV. The edge where reset is sampled high returns the unit to IDLE with `o_w_out`=0, `o_w_busy`=0, `o_w_done`=0, `o_w_div0`=0, and all internal registers cleared. Reset has priority over `i_w_start` on the same edge.

## Timing
Cycle *n* is the cycle right after the accepting edge.
- **Subtract:** latency 1. `o_w_done` and the result are valid in cycle 1.
- **Divide by zero:** latency 1, same as subtract.
- **Divide:** `o_w_busy`=1 in cycles 1..`p_width`+1. `o_w_done` and the result are valid in cycle `p_width`+1.
- **Throughput:** the earliest new accept is the edge ending the first IDLE cycle after DONE. The minimum issue interval is therefore 2 cycles for subtract and `p_width`+2 cycles for divide.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.

## Configuration
- **Macro:** `DIVSUB_EARLY_OUT_EN`.
- **Defined:** a divide with `b`≠0 and `a` < `b` skips DIV and goes IDLE→DONE. `o_w_out` = {`a`, 0} and `o_w_div0`=0. Latency is 1.
- **Undefined:** every divide with `b`≠0 runs the full `p_width` DIV steps, latency `p_width`+1. Result values are identical in both builds; only latency differs.

## Test plan
All scenarios use `p_width`=4.
1. Reset for 2 cycles → `o_w_out`=0x00 and `o_w_busy`=`o_w_done`=`o_w_div0`=0. Then sub `a`=9, `b`=3 → `o_w_out`=0x06 and `o_w_done` in cycle 1.
2. Sub `a`=3, `b`=9 → `o_w_out`=0x1A (borrow bit 4 set) and `o_w_div0`=0. Between ops the output holds 0x1A through IDLE.
3. Div `a`=13, `b`=4 → `o_w_busy` in cycles 1..5, `o_w_done` only in cycle 5, `o_w_out`=0x13 (r=1, q=3). Also div 15/1 → 0x0F, and 15/15 → 0x01.
4. Div `a`=7, `b`=0 → `o_w_out`=0x7F and `o_w_div0`=1 in cycle 1. A following sub 5−5 → `o_w_out`=0x00 and `o_w_div0`=0.
5. Start div 13/4, then pulse `i_w_start` with sub operands in cycles 2 and 5 → both are ignored and the result is 0x13. Separately, assert reset in cycle 3 of a divide → `o_w_busy`=0 and `o_w_out`=0x00 next cycle, no `o_w_done` pulse, and a new start is accepted immediately.
6. Div `a`=2, `b`=9 → `o_w_out`=0x20. Latency is 1 with `DIVSUB_EARLY_OUT_EN` defined and 5 without.
